// File: rtl/i2s_stereo_player.sv
// I2S stereo transmitter on the codec bit clock: frame FIFO, MSB-first serializer
// aligned to LRCK with one-bit delay, underrun flag and played-seconds counter.
module i2s_stereo_player #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int FS         = 32000,
  parameter int SEC_W      = 4
) (
  input  logic                               i_bclk,
  input  logic                               i_rst_n,
  input  logic                               i_daclrck,
  input  logic                               i_en,
  input  logic                               i_mono,
  input  logic                               i_clear,
  input  logic                               i_valid,
  input  logic [DATA_W-1:0]                  i_left,
  input  logic [DATA_W-1:0]                  i_right,
  output logic                               o_ready,
  output logic                               o_aud_dacdat,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_level,
  output logic                               o_underrun,
  output logic [SEC_W-1:0]                   o_second
);
  localparam int LVL_W = $clog2(FIFO_DEPTH+1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int BIT_W = $clog2(DATA_W);
  localparam int FC_W  = (FS > 1) ? $clog2(FS) : 1;

  typedef struct packed {
    logic [DATA_W-1:0] l;
    logic [DATA_W-1:0] r;
  } frame_t;

  typedef enum logic [1:0] {S_IDLE, S_LEFT, S_RIGHT} state_t;

  frame_t            mem [FIFO_DEPTH];
  frame_t            head;
  logic [PTR_W-1:0]  wptr, rptr;
  logic              lrck_d, left_edge, right_edge;
  logic              push, pop, start, starve, empty;
  logic [DATA_W-1:0] hold_r, shreg, ld_word;
  logic [BIT_W-1:0]  bit_cnt;
  logic [FC_W-1:0]   fcnt;
  logic              ld, go_zero;
  state_t            state, state_nxt;

  assign left_edge  = lrck_d & ~i_daclrck;
  assign right_edge = ~lrck_d & i_daclrck;
  assign empty      = (o_level == '0);
  assign o_ready    = (o_level < LVL_W'(FIFO_DEPTH));
  assign push       = i_valid && o_ready && !i_clear;
  assign start      = left_edge && i_en && !i_clear;
  // an empty FIFO at a left edge is a starve even if a push lands this cycle
  assign pop        = start && !empty;
  assign starve     = start && empty;
  assign head       = mem[rptr];

  always_ff @(posedge i_bclk)
    if (push) mem[wptr] <= '{l: i_left, r: i_right};

  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr <= '0; rptr <= '0; o_level <= '0; lrck_d <= 1'b0;
      hold_r <= '0; o_underrun <= 1'b0; fcnt <= '0; o_second <= '0;
    end else begin
      lrck_d     <= i_daclrck;
      o_underrun <= starve;
      if (i_clear) begin
        wptr <= '0; rptr <= '0; o_level <= '0; fcnt <= '0; o_second <= '0;
      end else begin
        if (push) wptr <= wptr + 1'b1;
        if (pop)  rptr <= rptr + 1'b1;
        o_level <= o_level + LVL_W'(push) - LVL_W'(pop);
        if (pop) begin
          hold_r <= i_mono ? head.l : head.r;
          if (fcnt == FC_W'(FS-1)) begin
            fcnt     <= '0;
            o_second <= o_second + 1'b1;
          end else begin
            fcnt <= fcnt + 1'b1;
          end
        end else if (starve) begin
          hold_r <= '0;
        end
      end
    end
  end

  always_ff @(posedge i_bclk or negedge i_rst_n)
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;

  always_comb begin
    state_nxt = state;
    ld        = 1'b0;
    ld_word   = '0;
    go_zero   = 1'b0;
    if (i_clear) begin
      state_nxt = S_IDLE;
      go_zero   = 1'b1;
    end else if (left_edge) begin
      if (i_en) begin
        state_nxt = S_LEFT;
        ld        = 1'b1;
        ld_word   = empty ? '0 : head.l;
      end else begin
        state_nxt = S_IDLE;
        go_zero   = 1'b1;
      end
    end else if (right_edge) begin
      if (state == S_LEFT) begin
        state_nxt = S_RIGHT;
        ld        = 1'b1;
        ld_word   = hold_r;
      end else begin
        state_nxt = S_IDLE;
        go_zero   = 1'b1;
      end
    end
  end

  // MSB goes out on the edge cycle; bit_cnt counts the DATA_W-1 bits still owed
  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_aud_dacdat <= 1'b0; shreg <= '0; bit_cnt <= '0;
    end else if (ld) begin
      o_aud_dacdat <= ld_word[DATA_W-1];
      shreg        <= ld_word << 1;
      bit_cnt      <= BIT_W'(DATA_W-1);
    end else if (go_zero) begin
      o_aud_dacdat <= 1'b0; shreg <= '0; bit_cnt <= '0;
    end else if (bit_cnt != '0) begin
      o_aud_dacdat <= shreg[DATA_W-1];
      shreg        <= shreg << 1;
      bit_cnt      <= bit_cnt - 1'b1;
    end else begin
      o_aud_dacdat <= 1'b0;
    end
  end
endmodule

// File: doc/i2s_stereo_player.md
# i2s_stereo_player

Parametrised I2S transmitter for the audio datapath, driven from the codec bit clock. It buffers stereo frames from the upstream sample source in a small FIFO with a valid/ready handshake. It serialises each frame MSB-first onto the DAC data line, aligned to the codec's LRCK. It also maintains a played-time seconds counter, flags FIFO underrun, and supports a mono mode and a synchronous clear.

## Interface
- DATA_W, 16, bits per channel sample (8..32)
- FIFO_DEPTH, 4, frames buffered; power of 2, ≥2
- FS, 32000, frames per second, used by the seconds counter
- SEC_W, 4, width of the seconds output
- i_bclk  in  1  codec bit clock; all logic on posedge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_daclrck  in  1  codec LRCK; low = left half-frame, high = right half-frame
- i_en  in  1  play enable
- i_mono  in  1  right channel replays the left sample
- i_clear  in  1  synchronous flush of FIFO, serializer and seconds counter
- i_valid  in  1  upstream frame valid
- i_left  in  DATA_W  left sample
- i_right  in  DATA_W  right sample
- o_ready  out  1  FIFO can accept a frame
- o_aud_dacdat  out  1  serial DAC data
- o_level  out  $clog2(FIFO_DEPTH+1)  frames in FIFO
- o_underrun  out  1  one-cycle pulse on a starved left edge
- o_second  out  SEC_W  seconds played

## Operation
- FIFO:
  - Push when i_valid && o_ready; o_ready = (o_level < FIFO_DEPTH), combinational from the registered count.
  - Push and pop in the same cycle leaves o_level unchanged.
  - If the FIFO is empty, a same-cycle push still lands (count becomes 1) and the pop is treated as an underrun.
- Edge detect: lrck_d samples i_daclrck each cycle and resets to 0.
  - Falling edge (lrck_d=1, i_daclrck=0) = left edge.
  - Rising edge = right edge.
- States: S_IDLE, S_LEFT, S_RIGHT, plus a bit counter of width $clog2(DATA_W).
- Left edge, i_en=1, FIFO non-empty:
  - Pop the frame into the left/right holding registers (right = left if i_mono).
  - Load the left shift register and enter S_LEFT.
- Left edge, i_en=1, FIFO empty:
  - Holding registers are zeroed and o_underrun pulses.
  - Enter S_LEFT and shift zeros.
- Left edge, i_en=0: go to S_IDLE; nothing is popped.
- Right edge from S_LEFT: load the held right sample and enter S_RIGHT.
- Right edge from S_IDLE (e.g. enable asserted mid-frame): stay in S_IDLE and output zeros.
- Serialising:
  - On the edge cycle, o_aud_dacdat <= sample[DATA_W-1].
  - On each of the next DATA_W-1 cycles, shift out the next lower bit.
  - After the LSB, o_aud_dacdat <= 0 until the next edge.
- Truncation: an edge arriving before DATA_W bits are sent aborts the current word and starts the new one.
- Seconds counter:
  - A frame counter 0..FS-1 increments on every successful pop (underrun frames are not counted).
  - At FS-1 it wraps to 0 and o_second increments, wrapping modulo 2^SEC_W.
- i_clear (priority over everything):
  - Empty the FIFO, drop any same-cycle push, zero the frame counter and o_second.
  - Go to S_IDLE with o_aud_dacdat <= 0.
  - lrck_d still updates.

## Timing
- Reset values: o_aud_dacdat=0, o_ready=1, o_level=0, o_underrun=0, o_second=0, state S_IDLE, lrck_d=0, FIFO pointers and frame counter 0.
- Pushed frame visible in o_level the cycle after the push.
- Data latency: MSB is registered at the posedge where the edge is detected, i.e. valid on the line one bclk after LRCK changes (I2S one-bit delay). LSB is output DATA_W-1 cycles later.
- Pop happens in the left-edge cycle; o_level decrements and o_ready re-asserts on the next cycle.
- o_underrun is high for exactly the cycle after the starved left edge.
- If i_daclrck is high at reset release, the first detected edge is a right edge; it outputs zeros and playback starts at the first genuine falling edge.
- Reset mid-word: output forced to 0 immediately (async); no partial word resumes.

## Test plan
- Reset then hold: all outputs at reset values; o_ready=1; o_aud_dacdat=0 through several LRCK periods with i_en=0.
- Push one frame L=16'hA5F0, R=16'h0F0F, i_en=1, 64-bclk frames:
  - 1010010111110000 follows the falling edge, 0000111100001111 follows the rising edge, zeros fill the remainder.
  - o_level goes 1→0.
- i_mono=1, L=16'h8001, R=16'hFFFF: both half-frames carry 1000000000000001.
- FIFO_DEPTH=4 with 5 back-to-back valids and no LRCK edges:
  - 4 accepted, o_ready=0, o_level=4.
  - The next left edge pops one; o_ready returns high a cycle later and the 5th frame is accepted.
- Empty FIFO, i_en=1: every left edge gives o_underrun=1 for one cycle and an all-zero frame; o_second does not advance.
- FS=4, SEC_W=2, continuous supply:
  - o_second steps every 4 played frames: 0,1,2,3,0.
  - i_clear asserted mid-left-word: line goes 0, o_level=0, o_second=0, next popped frame plays from MSB.
